// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encodings and slice partitioning helper shared by the pipelined barrel shifter
package shifter_pkg;
    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_ROTR = 2'b11;
    function automatic int stages_per_slice(input int stages, input int depth);
        return (stages + depth - 1) / depth;
    endfunction
endpackage

// File: rtl/shift_slice.sv
// shift_slice: one register slice applying binary stages FIRST..FIRST+COUNT-1; rotate wrap only with SHIFTER_ROTATE_EN
module shift_slice import shifter_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4,
    parameter int FIRST = 0,
    parameter int COUNT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     advance,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_amt,
    output logic [1:0]               out_mode,
    output logic [TAG_W-1:0]         out_tag
);
    logic [WIDTH-1:0] shifted;
    function automatic logic [WIDTH-1:0] stage(input logic [WIDTH-1:0] x, input logic [1:0] m, input int n);
        logic [WIDTH-1:0] wrap;
`ifdef SHIFTER_ROTATE_EN
        wrap = m == MODE_ROTR ? x << (WIDTH - n) : m == MODE_SRA ? {WIDTH{x[WIDTH-1]}} << (WIDTH - n) : '0;
`else
        wrap = m == MODE_SRA ? {WIDTH{x[WIDTH-1]}} << (WIDTH - n) : '0;
`endif
        return m == MODE_SLL ? x << n : (x >> n) | wrap;
    endfunction
    // apply the binary shift stages owned by this slice
    always_comb begin
        shifted = in_data;
        for (int k = 0; k < COUNT; k++)
            if (in_amt[FIRST + k]) shifted = stage(shifted, in_mode, 1 << (FIRST + k));
    end
    // capture the beat whenever the slice advances
    always_ff @(posedge clk)
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_mode  <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_amt   <= in_amt;
            out_mode  <= in_mode;
            out_tag   <= in_tag;
        end
endmodule

// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter: elastic pipelined SLL/SRL/SRA/ROTR shifter; ROTR compiled only with SHIFTER_ROTATE_EN
module pipe_barrel_shifter import shifter_pkg::*; #(
    parameter int WIDTH      = 64,
    parameter int PIPE_DEPTH = 3,
    parameter int TAG_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [$clog2(WIDTH)-1:0]    in_amt,
    input  logic [1:0]                  in_mode,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        out_zero,
    output logic [$clog2(PIPE_DEPTH):0] occupancy
);
    localparam int LW  = $clog2(WIDTH);
    localparam int OW  = $clog2(PIPE_DEPTH) + 1;
    localparam int SPS = stages_per_slice(LW, PIPE_DEPTH);
    logic [PIPE_DEPTH:0]   v;
    logic [PIPE_DEPTH-1:0] adv;
    logic [WIDTH-1:0]      data [PIPE_DEPTH+1];
    logic [LW-1:0]         amt  [PIPE_DEPTH+1];
    logic [1:0]            mode [PIPE_DEPTH+1];
    logic [TAG_W-1:0]      tag  [PIPE_DEPTH+1];
    assign v[0]    = in_valid;
    assign data[0] = in_data;
    assign amt[0]  = in_amt;
    assign mode[0] = in_mode;
    assign tag[0]  = in_tag;
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_slice
        localparam int F = i * SPS;
        localparam int C = LW - F > SPS ? SPS : (LW - F > 0 ? LW - F : 0);
        // a slice moves when any slice downstream of it holds a bubble or the sink accepts
        assign adv[i] = out_ready | ~&v[PIPE_DEPTH:i+1];
        shift_slice #(.WIDTH(WIDTH), .TAG_W(TAG_W), .FIRST(F), .COUNT(C)) u_slice (
            .clk(clk), .rst_n(rst_n), .advance(adv[i]),
            .in_valid(v[i]), .in_data(data[i]), .in_amt(amt[i]), .in_mode(mode[i]), .in_tag(tag[i]),
            .out_valid(v[i+1]), .out_data(data[i+1]), .out_amt(amt[i+1]), .out_mode(mode[i+1]), .out_tag(tag[i+1])
        );
    end
    assign in_ready  = rst_n & adv[0];
    assign out_valid = v[PIPE_DEPTH];
    assign out_data  = data[PIPE_DEPTH];
    assign out_tag   = tag[PIPE_DEPTH];
    assign out_zero  = ~|out_data;
    // beats in flight: up on accept, down on output handshake
    always_ff @(posedge clk)
        if (!rst_n) occupancy <= '0;
        else occupancy <= occupancy + OW'(in_valid & in_ready) - OW'(out_valid & out_ready);
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb_pipe_barrel_shifter: scoreboard bench for pipe_barrel_shifter (WIDTH=64, PIPE_DEPTH=3); honours SHIFTER_ROTATE_EN
module tb_pipe_barrel_shifter;
    localparam int W  = 64;
    localparam int D  = 3;
    localparam int TW = 4;
    localparam int LW = 6;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [W-1:0] in_data, out_data;
    logic [LW-1:0] in_amt;
    logic [1:0] in_mode;
    logic [TW-1:0] in_tag, out_tag;
    logic [$clog2(D):0] occupancy;
    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, acc_cnt = 0, out_cnt = 0;
    logic hold = 1'b0;
    logic [W-1:0] hd;
    logic [TW-1:0] ht;

    always #5 clk = ~clk;

    pipe_barrel_shifter #(.WIDTH(W), .PIPE_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero), .occupancy(occupancy)
    );

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [LW-1:0] a, input logic [1:0] m);
        logic signed [W-1:0] s;
        logic [2*W-1:0] dd;
        s = d;
        dd = {d, d};
        if (m == 2'b00) return d << a;
        if (m == 2'b10) return s >>> a;
`ifdef SHIFTER_ROTATE_EN
        if (m == 2'b11) return W'(dd >> a);
`endif
        return d >> a;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard: push on accept, pop on output handshake, track occupancy and hold stability
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold = 1'b0;
        end else begin
            chk("occupancy", W'(occupancy), W'(sb.size()));
            if (hold) begin
                chk("hold_data", out_data, hd);
                chk("hold_tag", W'(out_tag), W'(ht));
            end
            if (in_valid && in_ready) begin
                sb.push_back('{ref_shift(in_data, in_amt, in_mode), in_tag});
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_tag", W'(out_tag), W'(e.tag));
                    chk("out_zero", W'(out_zero), W'(e.data == '0));
                end
            end
            hold = out_valid && !out_ready;
            hd = out_data;
            ht = out_tag;
        end
    end

    task automatic lat_test(input string name, input logic [W-1:0] d, input logic [LW-1:0] a,
                            input logic [1:0] m, input logic [W-1:0] exp, input logic exp_zero);
        int n;
        out_ready = 1'b1;
        in_data = d; in_amt = a; in_mode = m; in_tag = 4'(checks); in_valid = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, W'(in_ready), W'(1));
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            in_valid = 1'b0;
            if (out_valid) break;
        end
        chk({name, "_latency"}, W'(n), W'(D));
        chk({name, "_data"}, out_data, exp);
        chk({name, "_zero"}, W'(out_zero), W'(exp_zero));
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [W-1:0] d, input logic [TW-1:0] t);
        int n;
        in_data = d; in_amt = 6'($urandom); in_mode = 2'($urandom); in_tag = t; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=%0d required=<50", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int acc, oc, start, cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_occupancy", W'(occupancy), '0);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_tag", W'(out_tag), '0);
        chk("rst_out_zero", W'(out_zero), W'(1));
        chk("rst_in_ready", W'(in_ready), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        lat_test("sll63", 64'h1, 6'd63, 2'b00, 64'h8000000000000000, 1'b0);
        lat_test("sra4", 64'h8000000000000000, 6'd4, 2'b10, 64'hF800000000000000, 1'b0);
        lat_test("srl4", 64'h8000000000000000, 6'd4, 2'b01, 64'h0800000000000000, 1'b0);
`ifdef SHIFTER_ROTATE_EN
        lat_test("rotr1", 64'h1, 6'd1, 2'b11, 64'h8000000000000000, 1'b0);
`else
        lat_test("mode3_srl", 64'h1, 6'd1, 2'b11, 64'h0, 1'b1);
`endif
        for (int m = 0; m < 4; m++)
            lat_test("amt0", 64'hDEADBEEFCAFEF00D, 6'd0, 2'(m), 64'hDEADBEEFCAFEF00D, 1'b0);

        out_ready = 1'b0;
        acc = 0;
        oc = out_cnt;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_tag = 4'(i + 1);
            in_data = {$urandom, $urandom}; in_amt = 6'($urandom); in_mode = 2'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepts", W'(acc), W'(3));
        chk("bp_occupancy", W'(occupancy), W'(3));
        chk("bp_in_ready", W'(in_ready), '0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drained", W'(out_cnt - oc), W'(3));
        chk("bp_empty", W'(occupancy), '0);

        out_ready = 1'b0;
        issue({$urandom, $urandom}, 4'hA);
        issue({$urandom, $urandom}, 4'hB);
        @(negedge clk);
        chk("pre_rst_occupancy", W'(occupancy), W'(2));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", W'(in_ready), '0);
        @(posedge clk); #1;
        chk("mid_rst_occupancy", W'(occupancy), '0);
        chk("mid_rst_out_valid", W'(out_valid), '0);
        chk("mid_rst_out_zero", W'(out_zero), W'(1));
        rst_n = 1'b1;
        out_ready = 1'b1;
        oc = out_cnt;
        @(negedge clk);
        chk("post_rst_in_ready", W'(in_ready), W'(1));
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_output", W'(out_cnt - oc), '0);

        start = acc_cnt;
        cyc = 0;
        while (acc_cnt - start < 10000 && cyc < 60000) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = {$urandom, $urandom};
            in_amt = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            in_mode = 2'($urandom);
            in_tag = 4'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_accepts", W'(acc_cnt - start), W'(10000));
        chk("random_drained", W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_barrel_shifter.md
PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width; power of two, 8..128.
REQ-002 SHALL have parameter PIPE_DEPTH, default 3, number of register stages, 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 4, sideband tag width carried alongside data.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous and active-low; one clock only.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port in_amt  input  log2(WIDTH)  shift amount.
REQ-010 SHALL have port in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR.
REQ-011 SHALL have port in_tag  input  TAG_W  opaque sideband.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_data  output  WIDTH  shifted result.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the beat on out_data.
REQ-016 SHALL have port out_zero  output  1  out_data is all zeros.
REQ-017 SHALL have port occupancy  output  log2(PIPE_DEPTH)+1  number of valid beats in flight.

Function
REQ-018 SHALL decompose the shift into log2(WIDTH) binary stages (1,2,4,...), stage k active when in_amt[k]=1.
REQ-019 SHALL group binary stages into PIPE_DEPTH register slices, ceil(log2(WIDTH)/PIPE_DEPTH) stages per slice, the last slice taking the remainder.
REQ-020 SHALL register data, amount, mode, tag and valid at each slice output.
REQ-021 SHALL have latency exactly PIPE_DEPTH cycles from accepted input to out_valid with no backpressure.
REQ-022 SHALL accept an input beat when in_valid and in_ready are both 1.
REQ-023 SHALL advance slice i when slice i is empty or slice i+1 advances (last slice: out_ready=1); bubbles collapse.
REQ-024 SHALL drive in_ready = first slice empty or first slice advancing; combinational from out_ready permitted.
REQ-025 SHALL hold out_data, out_tag, out_zero stable while out_valid=1 and out_ready=0.
REQ-026 SHALL sustain one beat per cycle throughput with out_ready held 1.
REQ-027 SHALL fill vacated bits with 0 for SLL/SRL, with in_data[WIDTH-1] for SRA, and with the bits shifted out of bit 0 for ROTR.
REQ-028 SHALL pass in_data unchanged when in_amt=0 in every mode.
REQ-029 SHALL increment occupancy on accept, decrement on output handshake, leave it unchanged when both occur in the same cycle.
REQ-030 SHALL never exceed occupancy PIPE_DEPTH; in_ready=0 when full and out_ready=0.

Reset
REQ-031 SHALL, on clk edge with rst_n=0, clear all slice valid bits, occupancy to 0, out_valid to 0, out_data and out_tag to 0, out_zero to 1.
REQ-032 SHALL discard all in-flight beats when reset asserts mid-operation; no beat emitted after reset release without a new accept.
REQ-033 SHALL hold in_ready=0 while rst_n=0 and drive it 1 the first cycle after release.

Configuration
REQ-034 SHALL compile rotate support only when macro SHIFTER_ROTATE_EN is defined; mode 11 then performs ROTR.
REQ-035 SHALL, without SHIFTER_ROTATE_EN, treat mode 11 as SRL and omit the rotate wrap-around logic.

Structure
REQ-036 SHALL place mode encoding constants (SLL, SRL, SRA, ROTR) and the stages-per-slice calculation function in shared package shifter_pkg.
REQ-037 SHALL implement one register slice as sub-module shift_slice (parameters WIDTH, first stage index, stage count), instantiated PIPE_DEPTH times.

Verification
REQ-038 SHALL test WIDTH=64, PIPE_DEPTH=3: SLL in_data=0x1, amt=63, out_ready=1 -> out_data=0x8000000000000000 exactly 3 cycles after accept.
REQ-039 SHALL test SRA in_data=0x8000000000000000, amt=4 -> out_data=0xF800000000000000; SRL same -> 0x0800000000000000.
REQ-040 SHALL test ROTR (macro defined) in_data=0x1, amt=1 -> 0x8000000000000000; without macro -> 0x0, out_zero=1.
REQ-041 SHALL test out_ready=0 with 5 back-to-back inputs -> 3 accepted, occupancy=3, in_ready=0; release -> tags emerge in order, no loss or duplication.
REQ-042 SHALL test rst_n=0 for one cycle with occupancy=2 -> next cycle occupancy=0, out_valid=0, no stale output afterwards.
REQ-043 SHALL test random mode/amt/data, 10k beats, random out_ready -> match reference model, tags preserved in order.
